pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the five-stage MIPS core.
- Generalises the fixed E/M register: one module serves the D/E, E/M and M/W boundaries.
- Adds stage enable (stall hold), bubble insertion that keeps PC/BD, an exception-request flush that retargets PC to the handler, exception-code passthrough, and configurable Tnew decrement.
- Sits between two stage datapaths; feeds forwarding and hazard units.

Parameters:
- PAYLOAD_W, 160: width of the opaque payload bus (A2, RD2, ALUout, PC8, imm32, WhichtoReg, RegDst, DM_type and so on), concatenated by the instantiating stage.
- PAYLOAD_RST, 0: payload value loaded on reset, req and bubble.
- TNEW_W, 2: width of the Tnew field.
- DEC_TNEW, 1: 1 = registered Tnew is saturating input−1; 0 = passthrough.
- EXC_W, 5: width of the exception-code field.
- PC_RST, 32'h0000_3000: PC loaded on reset.
- REQ_PC, 32'h0000_4180: PC loaded on exception request.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- en  in  1  1 = capture or bubble this cycle; 0 = hold
- bubble  in  1  insert NOP this cycle (stall bubble or branch squash)
- req  in  1  exception/interrupt flush
- in_pc  in  32  PC of incoming instruction
- in_bd  in  1  incoming instruction is in a branch delay slot
- in_a3  in  5  destination register
- in_wegrf  in  1  GRF write enable
- in_wedm  in  1  DM write enable
- in_tnew  in  TNEW_W  cycles until result is available
- in_exc  in  EXC_W  exception code (0 = none)
- in_payload  in  PAYLOAD_W  opaque data
- out_pc  out  32  registered PC
- out_bd  out  1  registered BD
- out_a3  out  5  registered destination
- out_wegrf  out  1  registered GRF write enable
- out_wedm  out  1  registered DM write enable
- out_tnew  out  TNEW_W  registered Tnew
- out_exc  out  EXC_W  registered exception code
- out_payload  out  PAYLOAD_W  registered payload
- out_valid  out  1  1 = real instruction; 0 = bubble or flushed slot

Behaviour:
- All outputs are registers. Single-cycle latency. No combinational in-to-out path.
- Priority per edge: reset > req > !en > bubble > load.
- reset:
  - out_pc = PC_RST, out_payload = PAYLOAD_RST.
  - All other outputs 0, including out_valid = 0.
- req (reset low):
  - Same as reset, except out_pc = REQ_PC.
  - req overrides en = 0 and bubble.
- en = 0 (no reset, no req):
  - Every output holds, including out_tnew (no decrement while held) and out_valid.
  - bubble is ignored.
- bubble = 1 with en = 1:
  - out_pc = in_pc, out_bd = in_bd. The PC is kept so that CP0 EPC/BD stay correct if an interrupt lands on the bubble.
  - out_a3 = 0, out_wegrf = 0, out_wedm = 0, out_tnew = 0, out_exc = 0.
  - out_payload = PAYLOAD_RST, out_valid = 0.
- load (en = 1, bubble = 0):
  - All fields are captured from their inputs.
  - out_valid = 1.
  - out_wegrf = in_wegrf AND (in_a3 != 0). Writes to $0 are never advertised to forwarding.
  - out_tnew: if DEC_TNEW = 1, (in_tnew == 0) ? 0 : in_tnew − 1, with no wrap below zero; if DEC_TNEW = 0, in_tnew.
  - out_exc = in_exc unmodified. A non-zero code does not alter the other fields.
- Mid-operation reset or req takes effect on the same edge regardless of en or bubble. The following cycle resumes normal priority.
- in_tnew at maximum (2'b11 with TNEW_W = 2) decrements to 2'b10. No special case.

Decomposition:
- Shared constants go in macro.v as `define:
  - `PC_Reset (32'h3000)
  - `PC_Handler (32'h4180)
  - `Tnew_W
  - `Exc_W
  - the per-field Initial values used to build PAYLOAD_RST at each instantiation
- One natural sub-module: tnew_sat_dec (TNEW_W in, TNEW_W out, saturating decrement; DEC_TNEW selects it or bypass).
- The payload field packing/unpacking is a macro-free concatenation done in the parent stage, not in this block.

Test Plan:
- Reset: assert reset 1 cycle with en = 1, in_pc = 32'h3008, in_tnew = 2 → out_pc = 32'h3000, out_tnew = 0, out_valid = 0, out_payload = PAYLOAD_RST; deassert, next edge loads out_pc = 32'h3008.
- Load and Tnew: DEC_TNEW = 1; in_tnew sequence 2, 1, 0 → out_tnew 1, 0, 0 on successive edges. DEC_TNEW = 0 instance, in_tnew = 2 → out_tnew = 2.
- $0 suppression: in_a3 = 0, in_wegrf = 1 → out_wegrf = 0. in_a3 = 5'd8 → out_wegrf = 1.
- Hold: load in_pc = 32'h3010; then en = 0 for 3 cycles while inputs change and bubble = 1 → outputs frozen at the 32'h3010 values. en back to 1 → new inputs captured.
- Bubble: en = 1, bubble = 1, in_pc = 32'h3020, in_bd = 1, in_wegrf = 1, in_wedm = 1, in_tnew = 2, in_exc = 5'd4 → out_pc = 32'h3020, out_bd = 1, out_wegrf = 0, out_wedm = 0, out_tnew = 0, out_exc = 0, out_valid = 0.
- Req priority: req = 1 with en = 0 and bubble = 1, in_pc = 32'h3030 → out_pc = 32'h4180, all other outputs reset values. Also reset = 1 and req = 1 on the same edge → out_pc = 32'h3000.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants and decode helpers for the inter-stage pipeline registers.
// Latency: n/a (package only).
// Backpressure: n/a; stall is expressed through the stage enable of each register.
package pipe_stage_reg_pkg;

  // Reset and exception-handler entry points of the core.
  localparam logic [31:0] PC_RESET   = 32'h0000_3000;
  localparam logic [31:0] PC_HANDLER = 32'h0000_4180;

  // Default field widths shared by every stage boundary.
  localparam int TNEW_W_DEF    = 2;
  localparam int EXC_W_DEF     = 5;
  localparam int A3_W          = 5;
  localparam int PAYLOAD_W_DEF = 160;

  // What a stage register does on the coming edge.
  typedef enum logic [2:0] {
    ACT_RESET  = 3'd0,
    ACT_REQ    = 3'd1,
    ACT_HOLD   = 3'd2,
    ACT_BUBBLE = 3'd3,
    ACT_LOAD   = 3'd4
  } stage_act_e;

  // Resolve the control inputs into one action: reset > req > hold > bubble > load.
  function automatic stage_act_e pick_action(input logic reset,
                                             input logic req,
                                             input logic en,
                                             input logic bubble);
    stage_act_e act;
    if (reset)       act = ACT_RESET;
    else if (req)    act = ACT_REQ;
    else if (!en)    act = ACT_HOLD;
    else if (bubble) act = ACT_BUBBLE;
    else             act = ACT_LOAD;
    return act;
  endfunction

  // A write to $0 is architecturally a no-op, so it must never look like a
  // producer to the forwarding/hazard logic.
  function automatic logic grf_write_visible(input logic            we,
                                             input logic [A3_W-1:0] a3);
    return we && (a3 != '0);
  endfunction

endpackage

// File: rtl/tnew_sat_dec.sv
// Tnew ageing for one stage boundary: saturating decrement or straight bypass.
// Latency: combinational, zero cycles.
// Backpressure: none; the owning register decides whether the result is captured.
module tnew_sat_dec #(
  parameter int TNEW_W   = 2,
  parameter bit DEC_TNEW = 1'b1
) (
  input  logic [TNEW_W-1:0] tnew_in,
  output logic [TNEW_W-1:0] tnew_out
);

  generate
    if (DEC_TNEW) begin : g_dec
      // One stage closer to the result, but never wrap below "ready now".
      always_comb begin
        tnew_out = tnew_in;
        if (tnew_in != '0) begin
          tnew_out = tnew_in - 1'b1;
        end
      end
    end else begin : g_bypass
      // Boundaries that do not age Tnew pass it through untouched.
      always_comb begin
        tnew_out = tnew_in;
      end
    end
  endgenerate

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic D/E, E/M, M/W pipeline register with stall hold, bubble and exception flush.
// Latency: one cycle, every output registered, no in-to-out combinational path.
// Backpressure: en=0 freezes all state (Tnew not aged); bubble/req override the captured instruction.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                     PAYLOAD_W   = PAYLOAD_W_DEF,
  parameter logic [PAYLOAD_W-1:0]   PAYLOAD_RST = '0,
  parameter int                     TNEW_W      = TNEW_W_DEF,
  parameter bit                     DEC_TNEW    = 1'b1,
  parameter int                     EXC_W       = EXC_W_DEF,
  parameter logic [31:0]            PC_RST      = PC_RESET,
  parameter logic [31:0]            REQ_PC      = PC_HANDLER
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 bubble,
  input  logic                 req,
  input  logic [31:0]          in_pc,
  input  logic                 in_bd,
  input  logic [A3_W-1:0]      in_a3,
  input  logic                 in_wegrf,
  input  logic                 in_wedm,
  input  logic [TNEW_W-1:0]    in_tnew,
  input  logic [EXC_W-1:0]     in_exc,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic [31:0]          out_pc,
  output logic                 out_bd,
  output logic [A3_W-1:0]      out_a3,
  output logic                 out_wegrf,
  output logic                 out_wedm,
  output logic [TNEW_W-1:0]    out_tnew,
  output logic [EXC_W-1:0]     out_exc,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_valid
);

  stage_act_e          act;
  logic [TNEW_W-1:0]   tnew_aged;
  logic                wegrf_vis;

  tnew_sat_dec #(
    .TNEW_W   (TNEW_W),
    .DEC_TNEW (DEC_TNEW)
  ) u_tnew_dec (
    .tnew_in  (in_tnew),
    .tnew_out (tnew_aged)
  );

  // Decode the per-edge action and the forwarding-visible write enable.
  always_comb begin
    act       = pick_action(reset, req, en, bubble);
    wegrf_vis = grf_write_visible(in_wegrf, in_a3);
  end

  // State update; the bubble keeps PC/BD so an interrupt taken on the bubble
  // still reports the right EPC and delay-slot flag.
  always_ff @(posedge clk) begin
    case (act)
      ACT_RESET, ACT_REQ: begin
        out_pc      <= (act == ACT_RESET) ? PC_RST : REQ_PC;
        out_bd      <= 1'b0;
        out_a3      <= '0;
        out_wegrf   <= 1'b0;
        out_wedm    <= 1'b0;
        out_tnew    <= '0;
        out_exc     <= '0;
        out_payload <= PAYLOAD_RST;
        out_valid   <= 1'b0;
      end
      ACT_BUBBLE: begin
        out_pc      <= in_pc;
        out_bd      <= in_bd;
        out_a3      <= '0;
        out_wegrf   <= 1'b0;
        out_wedm    <= 1'b0;
        out_tnew    <= '0;
        out_exc     <= '0;
        out_payload <= PAYLOAD_RST;
        out_valid   <= 1'b0;
      end
      ACT_LOAD: begin
        out_pc      <= in_pc;
        out_bd      <= in_bd;
        out_a3      <= in_a3;
        out_wegrf   <= wegrf_vis;
        out_wedm    <= in_wedm;
        out_tnew    <= tnew_aged;
        out_exc     <= in_exc;
        out_payload <= in_payload;
        out_valid   <= 1'b1;
      end
      default: begin
        // Stalled: every field, including Tnew and valid, holds its value.
        out_pc      <= out_pc;
        out_bd      <= out_bd;
        out_a3      <= out_a3;
        out_wegrf   <= out_wegrf;
        out_wedm    <= out_wedm;
        out_tnew    <= out_tnew;
        out_exc     <= out_exc;
        out_payload <= out_payload;
        out_valid   <= out_valid;
      end
    endcase
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a decrementing and a passthrough instance driven in lockstep.
// Latency: expected state pushed per edge, popped and compared one edge later.
// Backpressure: exercises en=0 hold, bubble and req/reset priority.
module tb_pipe_stage_reg;

  localparam int          PW    = 160;
  localparam logic [PW-1:0] PRST = {5{32'hDEAD_BEEF}};
  localparam logic [31:0] PCR   = 32'h0000_3000;
  localparam logic [31:0] PCH   = 32'h0000_4180;

  logic          clk;
  logic          reset, en, bubble, req;
  logic [31:0]   in_pc;
  logic          in_bd;
  logic [4:0]    in_a3;
  logic          in_wegrf, in_wedm;
  logic [1:0]    in_tnew;
  logic [4:0]    in_exc;
  logic [PW-1:0] in_payload;

  logic [31:0]   out_pc,      nd_pc;
  logic          out_bd,      nd_bd;
  logic [4:0]    out_a3,      nd_a3;
  logic          out_wegrf,   nd_wegrf;
  logic          out_wedm,    nd_wedm;
  logic [1:0]    out_tnew,    nd_tnew;
  logic [4:0]    out_exc,     nd_exc;
  logic [PW-1:0] out_payload, nd_payload;
  logic          out_valid,   nd_valid;

  pipe_stage_reg #(
    .PAYLOAD_W(PW), .PAYLOAD_RST(PRST), .TNEW_W(2), .DEC_TNEW(1'b1),
    .EXC_W(5), .PC_RST(PCR), .REQ_PC(PCH)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .bubble(bubble), .req(req),
    .in_pc(in_pc), .in_bd(in_bd), .in_a3(in_a3), .in_wegrf(in_wegrf),
    .in_wedm(in_wedm), .in_tnew(in_tnew), .in_exc(in_exc), .in_payload(in_payload),
    .out_pc(out_pc), .out_bd(out_bd), .out_a3(out_a3), .out_wegrf(out_wegrf),
    .out_wedm(out_wedm), .out_tnew(out_tnew), .out_exc(out_exc),
    .out_payload(out_payload), .out_valid(out_valid)
  );

  pipe_stage_reg #(
    .PAYLOAD_W(PW), .PAYLOAD_RST(PRST), .TNEW_W(2), .DEC_TNEW(1'b0),
    .EXC_W(5), .PC_RST(PCR), .REQ_PC(PCH)
  ) dut_nd (
    .clk(clk), .reset(reset), .en(en), .bubble(bubble), .req(req),
    .in_pc(in_pc), .in_bd(in_bd), .in_a3(in_a3), .in_wegrf(in_wegrf),
    .in_wedm(in_wedm), .in_tnew(in_tnew), .in_exc(in_exc), .in_payload(in_payload),
    .out_pc(nd_pc), .out_bd(nd_bd), .out_a3(nd_a3), .out_wegrf(nd_wegrf),
    .out_wedm(nd_wedm), .out_tnew(nd_tnew), .out_exc(nd_exc),
    .out_payload(nd_payload), .out_valid(nd_valid)
  );

  typedef struct {
    logic [31:0]   pc;
    logic          bd;
    logic [4:0]    a3;
    logic          wegrf;
    logic          wedm;
    logic [1:0]    tnew;
    logic [1:0]    tnew_nd;
    logic [4:0]    exc;
    logic [PW-1:0] payload;
    logic          valid;
  } exp_t;

  exp_t m;
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model of one edge, written from the priority rules.
  function automatic exp_t model(input exp_t cur);
    exp_t n;
    n = cur;
    if (reset || req) begin
      n.pc = reset ? PCR : PCH;
      n.bd = 1'b0; n.a3 = '0; n.wegrf = 1'b0; n.wedm = 1'b0;
      n.tnew = '0; n.tnew_nd = '0; n.exc = '0; n.payload = PRST; n.valid = 1'b0;
    end else if (!en) begin
      n = cur;
    end else if (bubble) begin
      n.pc = in_pc; n.bd = in_bd;
      n.a3 = '0; n.wegrf = 1'b0; n.wedm = 1'b0;
      n.tnew = '0; n.tnew_nd = '0; n.exc = '0; n.payload = PRST; n.valid = 1'b0;
    end else begin
      n.pc = in_pc; n.bd = in_bd; n.a3 = in_a3;
      n.wegrf = in_wegrf && (in_a3 != 5'd0);
      n.wedm = in_wedm;
      n.tnew = (in_tnew == 2'd0) ? 2'd0 : in_tnew - 2'd1;
      n.tnew_nd = in_tnew;
      n.exc = in_exc; n.payload = in_payload; n.valid = 1'b1;
    end
    return n;
  endfunction

  // Inputs are already set (away from the rising edge); clock one edge and compare.
  task automatic cycle(input string tag);
    exp_t e;
    m = model(m);
    sb.push_back(m);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq({tag, ".pc"},      out_pc,      e.pc);
    check_eq({tag, ".bd"},      out_bd,      e.bd);
    check_eq({tag, ".a3"},      out_a3,      e.a3);
    check_eq({tag, ".wegrf"},   out_wegrf,   e.wegrf);
    check_eq({tag, ".wedm"},    out_wedm,    e.wedm);
    check_eq({tag, ".tnew"},    out_tnew,    e.tnew);
    check_eq({tag, ".exc"},     out_exc,     e.exc);
    check_eq({tag, ".payload"}, out_payload, e.payload);
    check_eq({tag, ".valid"},   out_valid,   e.valid);
    check_eq({tag, ".nd_tnew"}, nd_tnew,     e.tnew_nd);
    check_eq({tag, ".nd_pc"},   nd_pc,       e.pc);
    check_eq({tag, ".nd_misc"},
             {nd_bd, nd_a3, nd_wegrf, nd_wedm, nd_exc, nd_valid},
             {e.bd, e.a3, e.wegrf, e.wedm, e.exc, e.valid});
    check_eq({tag, ".nd_payload"}, nd_payload, e.payload);
    @(negedge clk);
  endtask

  task automatic set_in(input logic [31:0] pc, input logic bd, input logic [4:0] a3,
                        input logic wegrf, input logic wedm, input logic [1:0] tnew,
                        input logic [4:0] exc);
    in_pc = pc; in_bd = bd; in_a3 = a3; in_wegrf = wegrf; in_wedm = wedm;
    in_tnew = tnew; in_exc = exc;
    in_payload = {$urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    m = '{pc: '0, bd: 1'b0, a3: '0, wegrf: 1'b0, wedm: 1'b0, tnew: '0,
          tnew_nd: '0, exc: '0, payload: '0, valid: 1'b0};
    reset = 1'b1; req = 1'b0; en = 1'b1; bubble = 1'b0;
    set_in(32'h3008, 1'b0, 5'd3, 1'b1, 1'b0, 2'd2, 5'd0);
    @(negedge clk);

    // Reset with a live instruction on the inputs, then first load.
    cycle("reset");
    reset = 1'b0;
    cycle("first_load");

    // Tnew ageing 2,1,0 and the max value 3.
    set_in(32'h300c, 1'b0, 5'd9, 1'b1, 1'b0, 2'd2, 5'd0); cycle("tnew2");
    set_in(32'h3010, 1'b0, 5'd9, 1'b1, 1'b0, 2'd1, 5'd0); cycle("tnew1");
    set_in(32'h3014, 1'b0, 5'd9, 1'b1, 1'b0, 2'd0, 5'd0); cycle("tnew0");
    set_in(32'h3018, 1'b1, 5'd9, 1'b1, 1'b1, 2'd3, 5'd7); cycle("tnew3");

    // $0 write suppression.
    set_in(32'h301c, 1'b0, 5'd0, 1'b1, 1'b0, 2'd1, 5'd0); cycle("a3_zero");
    set_in(32'h3020, 1'b0, 5'd8, 1'b1, 1'b0, 2'd1, 5'd0); cycle("a3_eight");

    // Hold for three cycles with changing inputs and bubble asserted.
    set_in(32'h3010, 1'b1, 5'd12, 1'b1, 1'b1, 2'd2, 5'd3); cycle("hold_load");
    en = 1'b0; bubble = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(32'h3100 + 32'(i * 4), 1'b0, 5'(i + 1), 1'b0, 1'b0, 2'(i), 5'(i + 9));
      cycle("hold");
    end
    en = 1'b1; bubble = 1'b0;
    set_in(32'h3200, 1'b0, 5'd17, 1'b1, 1'b0, 2'd3, 5'd0); cycle("hold_release");

    // Bubble keeps PC/BD, clears everything else.
    bubble = 1'b1;
    set_in(32'h3020, 1'b1, 5'd6, 1'b1, 1'b1, 2'd2, 5'd4); cycle("bubble");
    bubble = 1'b0;

    // req beats en=0 and bubble; reset beats req.
    set_in(32'h3024, 1'b1, 5'd6, 1'b1, 1'b1, 2'd2, 5'd4); cycle("pre_req");
    req = 1'b1; en = 1'b0; bubble = 1'b1;
    set_in(32'h3030, 1'b1, 5'd6, 1'b1, 1'b1, 2'd2, 5'd4); cycle("req");
    req = 1'b0; en = 1'b1; bubble = 1'b0;
    set_in(32'h3034, 1'b0, 5'd5, 1'b1, 1'b0, 2'd1, 5'd0); cycle("post_req");
    reset = 1'b1; req = 1'b1;
    cycle("reset_and_req");
    reset = 1'b0; req = 1'b0;

    // Random mix with occasional reset/req.
    for (int i = 0; i < 60; i++) begin
      reset  = ($urandom_range(0, 19) == 0);
      req    = ($urandom_range(0, 14) == 0);
      en     = ($urandom_range(0, 3) != 0);
      bubble = ($urandom_range(0, 4) == 0);
      set_in({$urandom} & 32'h0000_fffc, 1'($urandom), 5'($urandom), 1'($urandom),
             1'($urandom), 2'($urandom), 5'($urandom));
      cycle("rand");
    end

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
